// File: rtl/collision_monitor_if.sv
// Sprite-overlap bus between the VGA scan / sprite delegates and collision_monitor.
// The master drives scan position and masks; the slave returns the collision verdict.
interface collision_monitor_if;
  logic        pix_en;
  logic [9:0]  vga_x;
  logic [8:0]  vga_y;
  logic        dino_grey;
  logic        obs_grey;
  logic        game_run;
  logic        collided;
  logic [15:0] frame_hits;
  logic [9:0]  hit_x;
  logic [8:0]  hit_y;

  modport master (
    output pix_en, vga_x, vga_y, dino_grey, obs_grey, game_run,
    input  collided, frame_hits, hit_x, hit_y
  );

  modport slave (
    input  pix_en, vga_x, vga_y, dino_grey, obs_grey, game_run,
    output collided, frame_hits, hit_x, hit_y
  );
endinterface

// File: rtl/collision_monitor.sv
// Frame-synchronous dino/obstacle collision judge with threshold and multi-frame confirmation.
// Optional first-overlap coordinate capture is built when COLLISION_DEBUG_EN is defined.
module collision_monitor #(
  parameter int unsigned ACTIVE_W = 640,
  parameter int unsigned ACTIVE_H = 480,
  parameter int unsigned THRESH   = 4,
  parameter int unsigned CONFIRM  = 2
) (
  input logic                clk,
  input logic                rst,
  collision_monitor_if.slave bus
);
  localparam logic [10:0] W_LIM     = 11'(ACTIVE_W);
  localparam logic [9:0]  H_LIM     = 10'(ACTIVE_H);
  localparam logic [15:0] THRESH_C  = 16'(THRESH);
  localparam logic [3:0]  CONFIRM_C = 4'(CONFIRM);

  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, ARMED = 2'd2, HIT = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [15:0] ovl_cnt_q, ovl_cnt_d;
  logic [3:0]  confirm_cnt_q, confirm_cnt_d;
  logic [15:0] frame_hits_q, frame_hits_d;
  logic        collided_q, collided_d;

  logic        in_area_s, ovl_pix_s, fs_s, qual_s;
  logic [15:0] ovl_base_s, ovl_next_s;
  logic [3:0]  confirm_inc_s;

  assign in_area_s = ({1'b0, bus.vga_x} < W_LIM) && ({1'b0, bus.vga_y} < H_LIM);
  assign ovl_pix_s = bus.pix_en && bus.dino_grey && bus.obs_grey && in_area_s;
  assign fs_s      = bus.pix_en && (bus.vga_x == 10'd0) && (bus.vga_y == 9'd0);
  // A pixel coincident with the frame start belongs to the new frame.
  assign ovl_base_s    = fs_s ? 16'd0 : ovl_cnt_q;
  assign ovl_next_s    = (ovl_pix_s && (ovl_base_s != 16'hFFFF)) ? ovl_base_s + 16'd1 : ovl_base_s;
  assign qual_s        = (ovl_cnt_q >= THRESH_C);
  assign confirm_inc_s = confirm_cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ovl_cnt_q     <= 16'd0;
      confirm_cnt_q <= 4'd0;
      frame_hits_q  <= 16'd0;
      collided_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ovl_cnt_q     <= ovl_cnt_d;
      confirm_cnt_q <= confirm_cnt_d;
      frame_hits_q  <= frame_hits_d;
      collided_q    <= collided_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.game_run) state_d = SYNC; else state_d = IDLE;
      SYNC:    if (!bus.game_run) state_d = IDLE; else if (fs_s) state_d = ARMED; else state_d = SYNC;
      ARMED: begin
        if (!bus.game_run) state_d = IDLE;
        else if (fs_s && qual_s && (confirm_inc_s == CONFIRM_C)) state_d = HIT;
        else state_d = ARMED;
      end
      HIT:     if (!bus.game_run) state_d = IDLE; else state_d = HIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovl_cnt_d     = ovl_cnt_q;
    confirm_cnt_d = confirm_cnt_q;
    frame_hits_d  = frame_hits_q;
    collided_d    = (state_d == HIT);
    if (!bus.game_run || (state_q == IDLE)) begin
      ovl_cnt_d     = 16'd0;
      confirm_cnt_d = 4'd0;
    end else begin
      case (state_q)
        SYNC:  ovl_cnt_d = ovl_next_s;
        ARMED: begin
          ovl_cnt_d = ovl_next_s;
          if (fs_s) begin
            frame_hits_d  = ovl_cnt_q;
            confirm_cnt_d = qual_s ? confirm_inc_s : 4'd0;
          end else begin
            confirm_cnt_d = confirm_cnt_q;
          end
        end
        HIT:     ovl_cnt_d = ovl_cnt_q;
        default: ovl_cnt_d = 16'd0;
      endcase
    end
  end

  assign bus.collided   = collided_q;
  assign bus.frame_hits = frame_hits_q;

`ifdef COLLISION_DEBUG_EN
  logic [9:0] shadow_x_q, hit_x_q;
  logic [8:0] shadow_y_q, hit_y_q;

  // Shadow the first overlap of each armed frame; publish it when the collision is declared.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_x_q <= 10'd0;
      shadow_y_q <= 9'd0;
      hit_x_q    <= 10'd0;
      hit_y_q    <= 9'd0;
    end else if (state_d == IDLE) begin
      shadow_x_q <= 10'd0;
      shadow_y_q <= 9'd0;
      hit_x_q    <= 10'd0;
      hit_y_q    <= 9'd0;
    end else begin
      if ((state_q == ARMED) && ovl_pix_s && (ovl_base_s == 16'd0)) begin
        shadow_x_q <= bus.vga_x;
        shadow_y_q <= bus.vga_y;
      end
      if ((state_q != HIT) && (state_d == HIT)) begin
        hit_x_q <= shadow_x_q;
        hit_y_q <= shadow_y_q;
      end
    end
  end

  assign bus.hit_x = hit_x_q;
  assign bus.hit_y = hit_y_q;
`else
  assign bus.hit_x = 10'd0;
  assign bus.hit_y = 9'd0;
`endif
endmodule

// File: tb/tb_collision_monitor.sv
// Directed self-checking bench for collision_monitor at default parameters.
module tb_collision_monitor;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  collision_monitor_if bus();

  collision_monitor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [9:0] x, input logic [8:0] y, input logic d, input logic o);
    bus.vga_x     = x;
    bus.vga_y     = y;
    bus.dino_grey = d;
    bus.obs_grey  = o;
    bus.pix_en    = 1'b1;
    tick();
    bus.pix_en    = 1'b0;
    bus.dino_grey = 1'b0;
    bus.obs_grey  = 1'b0;
  endtask

  task automatic ovl(input int n);
    for (int i = 0; i < n; i++) pix(10'(10 + i), 9'd20, 1'b1, 1'b1);
  endtask

  task automatic fs(input logic o);
    pix(10'd0, 9'd0, o, o);
  endtask

  task automatic start();
    bus.game_run = 1'b1;
    tick();
  endtask

  task automatic stop();
    bus.game_run = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] exp_hx;
    logic [31:0] exp_hy;
    n_checks      = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.pix_en    = 1'b0;
    bus.vga_x     = 10'd5;
    bus.vga_y     = 9'd5;
    bus.dino_grey = 1'b0;
    bus.obs_grey  = 1'b0;
    bus.game_run  = 1'b0;
`ifdef COLLISION_DEBUG_EN
    exp_hx = 32'd212;
    exp_hy = 32'd300;
`else
    exp_hx = 32'd0;
    exp_hy = 32'd0;
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset_collided", 32'(bus.collided), 32'd0);
    check("reset_frame_hits", 32'(bus.frame_hits), 32'd0);
    check("reset_hit_x", 32'(bus.hit_x), 32'd0);
    check("reset_hit_y", 32'(bus.hit_y), 32'd0);

    // Basic detection: partial frame, then two qualifying frames of 5.
    start();
    ovl(5);
    fs(1'b0);
    ovl(5);
    pix(10'd640, 9'd10, 1'b1, 1'b1);
    pix(10'd5, 9'd480, 1'b1, 1'b1);
    pix(10'd7, 9'd7, 1'b1, 1'b0);
    fs(1'b0);
    check("s1_hits_after_fs2", 32'(bus.frame_hits), 32'd5);
    check("s1_no_collide_fs2", 32'(bus.collided), 32'd0);
    pix(10'd212, 9'd300, 1'b1, 1'b1);
    ovl(4);
    check("s1_no_collide_pre_fs3", 32'(bus.collided), 32'd0);
    fs(1'b0);
    check("s1_collided_fs3", 32'(bus.collided), 32'd1);
    check("s1_hits_fs3", 32'(bus.frame_hits), 32'd5);
    check("s1_hit_x", 32'(bus.hit_x), exp_hx);
    check("s1_hit_y", 32'(bus.hit_y), exp_hy);
    fs(1'b0);
    check("s1_hit_holds", 32'(bus.collided), 32'd1);
    check("s1_hit_hits_frozen", 32'(bus.frame_hits), 32'd5);
    stop();
    check("s1_drop_collided", 32'(bus.collided), 32'd0);
    check("s1_drop_hit_x", 32'(bus.hit_x), 32'd0);

    // Below threshold for 10 frames, then exactly-threshold frames with an (0,0) overlap.
    start();
    fs(1'b0);
    for (int k = 0; k < 10; k++) begin
      ovl(3);
      fs(1'b0);
      check("s2_below_thresh", 32'(bus.collided), 32'd0);
    end
    check("s2_hits_3", 32'(bus.frame_hits), 32'd3);
    ovl(4);
    fs(1'b1);
    check("s2_hits_4", 32'(bus.frame_hits), 32'd4);
    check("s2_one_frame", 32'(bus.collided), 32'd0);
    ovl(3);
    fs(1'b0);
    check("s2_fs_pixel_new_frame", 32'(bus.frame_hits), 32'd4);
    check("s2_collided_at_thresh", 32'(bus.collided), 32'd1);
    stop();

    // Alternating qualifying and empty frames never confirm.
    start();
    fs(1'b0);
    for (int k = 0; k < 3; k++) begin
      ovl(5);
      fs(1'b0);
      check("s3_alt_hit_frame", 32'(bus.collided), 32'd0);
      fs(1'b0);
      check("s3_alt_empty_frame", 32'(bus.collided), 32'd0);
    end
    check("s3_hits_0", 32'(bus.frame_hits), 32'd0);
    stop();

    // Mid-frame start with a heavy partial frame is discarded.
    start();
    ovl(100);
    fs(1'b0);
    check("s4_partial_ignored", 32'(bus.collided), 32'd0);
    ovl(5);
    fs(1'b0);
    check("s4_first_full", 32'(bus.collided), 32'd0);
    check("s4_hits_5", 32'(bus.frame_hits), 32'd5);
    ovl(5);
    fs(1'b0);
    check("s4_second_full", 32'(bus.collided), 32'd1);
    stop();

    // Reset mid-ARMED with one frame confirmed.
    start();
    fs(1'b0);
    ovl(5);
    fs(1'b0);
    check("s5_armed_hits", 32'(bus.frame_hits), 32'd5);
    ovl(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s5_rst_collided", 32'(bus.collided), 32'd0);
    check("s5_rst_frame_hits", 32'(bus.frame_hits), 32'd0);
    check("s5_rst_hit_x", 32'(bus.hit_x), 32'd0);
    check("s5_rst_hit_y", 32'(bus.hit_y), 32'd0);
    tick();
    fs(1'b0);
    ovl(5);
    fs(1'b0);
    check("s5_fresh_first", 32'(bus.collided), 32'd0);
    ovl(5);
    fs(1'b0);
    check("s5_fresh_second", 32'(bus.collided), 32'd1);
    stop();
    check("s5_final_drop", 32'(bus.collided), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
